// File: rtl/key_loader_pkg.sv
// Shared types and constants for the key loader: FSM states, parity mode
// and a width helper for the internal counters.
package key_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Even parity: XOR over key bits plus parity bit must come out zero.
    localparam logic EVEN = 1'b0;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_par_shift.sv
// Serial key capture: shadow register filled LSB first, bit counter and a
// running parity accumulator that also absorbs the trailing parity bit.
module key_par_shift
    import key_loader_pkg::*;
#(
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             data_bit,
    output logic [KEY_W-1:0] shadow,
    output logic             full,
    output logic             par_ok
);

    localparam int            CW       = clog2(KEY_W + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(KEY_W);

    logic [CW-1:0]    bit_cnt_r;
    logic [KEY_W-1:0] shadow_r;
    logic             par_acc_r;

    // Capture key bits until full, then fold the parity bit into the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r <= {CW{1'b0}};
            shadow_r  <= {KEY_W{1'b0}};
            par_acc_r <= 1'b0;
        end else if (clear) begin
            bit_cnt_r <= {CW{1'b0}};
            shadow_r  <= {KEY_W{1'b0}};
            par_acc_r <= 1'b0;
        end else if (shift_en) begin
            if (bit_cnt_r != CNT_FULL) begin
                shadow_r  <= shadow_r | (KEY_W'(data_bit) << bit_cnt_r);
                bit_cnt_r <= bit_cnt_r + CW'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            par_acc_r <= par_acc_r ^ data_bit;
        end else begin
            par_acc_r <= par_acc_r;
        end
    end

    assign shadow = shadow_r;
    assign full   = (bit_cnt_r == CNT_FULL);
    assign par_ok = (par_acc_r == EVEN);

endmodule

// File: rtl/key_loader.sv
// Key loader: fetches a parity-protected key from OTP with timeout and
// retry, and holds the locked design in reset until the key is verified.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_W     = 8,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    output logic             otp_req,
    input  logic             otp_valid,
    input  logic             otp_bit,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid,
    output logic             design_rst,
    output logic             load_err
);

    localparam int            IW        = clog2(TIMEOUT + 1);
    localparam int            RW        = clog2(MAX_RETRY + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RTRY_LAST = RW'(MAX_RETRY - 1);

    state_t           state_r;
    state_t           next_s;
    logic [IW-1:0]    idle_cnt_r;
    logic [RW-1:0]    retry_cnt_r;
    logic [KEY_W-1:0] shadow_s;
    logic             full_s;
    logic             par_ok_s;
    logic             timeout_s;
    logic             fail_s;
    logic             last_try_s;
    logic             restart_s;
    logic             reload_ok_s;
    logic             shift_en_s;

    logic             otp_req_s;
    logic [KEY_W-1:0] key_s;
    logic             key_valid_s;
    logic             design_rst_s;
    logic             load_err_s;

    key_par_shift #(.KEY_W(KEY_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (restart_s),
        .shift_en (shift_en_s),
        .data_bit (otp_bit),
        .shadow   (shadow_s),
        .full     (full_s),
        .par_ok   (par_ok_s)
    );

    // Attempt-level events: timeout, failure, final attempt, restart of a fetch.
    always_comb begin
        shift_en_s  = (state_r == SHIFT) && otp_valid;
        timeout_s   = (state_r == SHIFT) && !otp_valid && (idle_cnt_r == IDLE_LAST);
        fail_s      = timeout_s || ((state_r == CHECK) && !par_ok_s);
        last_try_s  = (retry_cnt_r >= RTRY_LAST);
        reload_ok_s = reload && ((state_r == DONE) || (state_r == ERROR));
        restart_s   = (state_r == IDLE) || reload_ok_s || (fail_s && !last_try_s);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                next_s = SHIFT;
            end
            SHIFT: begin
                if (otp_valid && full_s) begin
                    next_s = CHECK;
                end else if (timeout_s) begin
                    next_s = last_try_s ? ERROR : SHIFT;
                end else begin
                    next_s = SHIFT;
                end
            end
            CHECK: begin
                if (par_ok_s) begin
                    next_s = DONE;
                end else begin
                    next_s = last_try_s ? ERROR : SHIFT;
                end
            end
            DONE: begin
                next_s = reload ? SHIFT : DONE;
            end
            ERROR: begin
                next_s = reload ? SHIFT : ERROR;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; key_o only ever carries a verified key.
    always_comb begin
        otp_req_s    = (next_s == SHIFT);
        key_valid_s  = (next_s == DONE);
        design_rst_s = (next_s != DONE);
        load_err_s   = (next_s == ERROR);
        if ((state_r == CHECK) && (next_s == DONE)) begin
            key_s = shadow_s;
        end else if (next_s == DONE) begin
            key_s = key_o;
        end else begin
            key_s = {KEY_W{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            otp_req    <= 1'b0;
            key_o      <= {KEY_W{1'b0}};
            key_valid  <= 1'b0;
            design_rst <= 1'b1;
            load_err   <= 1'b0;
        end else begin
            otp_req    <= otp_req_s;
            key_o      <= key_s;
            key_valid  <= key_valid_s;
            design_rst <= design_rst_s;
            load_err   <= load_err_s;
        end
    end

    // Idle-cycle counter for the OTP timeout; cleared on data and on each new attempt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (restart_s || (next_s != SHIFT) || otp_valid) begin
            idle_cnt_r <= {IW{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
        end
    end

    // Failed-attempt counter; a reload grants a fresh set of attempts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt_r <= {RW{1'b0}};
        end else if (reload_ok_s) begin
            retry_cnt_r <= {RW{1'b0}};
        end else if (fail_s) begin
            retry_cnt_r <= retry_cnt_r + RW'(1);
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Supplies the key to a key-locked FSM. The locked FSM consumes `keyinput`; this block produces it.
- Fetches the key serially from an OTP/secure-storage port, checks parity, retries on failure, and presents it on `key_o`.
- Holds the locked design in reset until a verified key is loaded.
- Sits between the OTP controller and the locked FSM's `keyinput*` and `rst` pins.

Parameters:
- KEY_W, 8, key width in bits (1..64).
- TIMEOUT, 255, maximum cycles without `otp_valid` while fetching before the attempt fails.
- MAX_RETRY, 3, total fetch attempts before entering ERROR (≥1).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- reload  in  1  single-cycle request to refetch the key; honoured only in DONE or ERROR.
- otp_req  out  1  level request to the OTP source; high while fetching.
- otp_valid  in  1  qualifies `otp_bit`; sampled only in SHIFT.
- otp_bit  in  1  serial data: key LSB first, KEY_W bits, then 1 even-parity bit.
- key_o  out  KEY_W  loaded key; drives the locked FSM `keyinput*`.
- key_valid  out  1  high while `key_o` holds a verified key.
- design_rst  out  1  reset to the locked FSM; high until key verified.
- load_err  out  1  high in ERROR.

Behaviour:
- All outputs are registered.
- Reset values: otp_req=0, key_o=0, key_valid=0, design_rst=1, load_err=0.
- Reset clears all internal state: state=IDLE, bit_cnt=0, idle_cnt=0, retry_cnt=0, shadow=0.
- States: IDLE, SHIFT, CHECK, DONE, ERROR.
- IDLE:
  - Unconditionally → SHIFT on the first clock after reset release.
  - otp_req rises at that edge.
- SHIFT:
  - Each cycle with otp_valid=1 and bit_cnt<KEY_W: shadow[bit_cnt]←otp_bit, bit_cnt++, idle_cnt←0.
  - The cycle with otp_valid=1 and bit_cnt==KEY_W captures the parity bit. At that edge: → CHECK, otp_req←0.
  - Each cycle with otp_valid=0: idle_cnt++.
  - idle_cnt reaching TIMEOUT counts as a failed attempt; handled exactly as a parity failure.
- CHECK (exactly 1 cycle):
  - pass = (XOR of shadow and parity bit == 0).
  - Pass → DONE. At the same edge: key_o←shadow, key_valid←1, design_rst←0.
  - Fail: retry_cnt++.
    - If the new retry_cnt < MAX_RETRY → SHIFT, with bit_cnt, idle_cnt, shadow cleared and otp_req←1.
    - Otherwise → ERROR.
- Timeout failure goes directly from SHIFT through the same fail path; there is no CHECK cycle.
- DONE:
  - Holds indefinitely.
  - reload=1 → SHIFT. At that edge: key_o←0, key_valid←0, design_rst←1, retry_cnt←0, otp_req←1.
- ERROR:
  - load_err=1, key_o=0, design_rst=1.
  - Exits only via rst, or via reload (same actions as from DONE, plus load_err←0).
- Ignored inputs:
  - reload in IDLE, SHIFT or CHECK.
  - otp_valid outside SHIFT.
- Latency, clean load with continuous otp_valid:
  - SHIFT entry to CHECK: KEY_W+1 cycles.
  - key_valid rises at the next edge.
  - Total: KEY_W+3 edges after reset release.
- key_o never shows partial or unverified data. shadow is internal only.
- Reset asserted mid-load: immediate return to reset values; design_rst=1 asynchronously.
- Counter widths: idle_cnt is clog2(TIMEOUT+1); retry_cnt is clog2(MAX_RETRY+1); bit_cnt is clog2(KEY_W+1).

Decomposition:
- Package `key_loader_pkg`:
  - State enum: IDLE, SHIFT, CHECK, DONE, ERROR.
  - Parity-mode constant: EVEN.
  - Function `clog2` for counter widths.
- One sub-module, `key_par_shift`:
  - Contains the shadow register, bit counter and running-parity accumulator.
  - Inputs: clear, shift_en, bit.
  - Outputs: shadow, full (bit_cnt==KEY_W), par_ok.
- The FSM, timeout counter and retry counter stay in the top.

Test Plan:
- Clean load: stream bits of 0xA5 LSB first, then parity 0, otp_valid continuous → key_o=0xA5, key_valid=1, design_rst=0 exactly 11 edges after reset release; otp_req low after the parity bit.
- Single parity error: first frame 0xA5 with parity 1, second frame correct → otp_req re-rises one edge after CHECK; final key_o=0xA5; load_err never asserted.
- Retry exhaustion (MAX_RETRY=3): three bad-parity frames → ERROR, load_err=1, key_o=0x00, design_rst=1; later otp_valid pulses are ignored.
- Timeout: otp_req high, otp_valid held 0 for 255 cycles → retry begins (retry_cnt=1). Repeat ×3 → ERROR.
- Reset mid-load after 4 bits → all outputs return to reset values asynchronously; the next fetch starts from bit 0 and loads 0x3C correctly.
- Reload from DONE (key 0xA5) → same edge: key_valid=0, design_rst=1, key_o=0. Then load 0x5A → key_o=0x5A; reload pulsed during SHIFT has no effect.
